// File: rtl/ls595_deser.sv
// ls595_deser -- multi-plane serial-in / parallel-out deserializer.
//
// Reassembles CHANNELS parallel LSB-first bitstreams into WIDTH-bit words.
// Each channel behaves like a 74LS595: a shift register feeds a storage
// register. A shared bit counter marks word boundaries, and a valid/ready
// handshake hands finished words to the consumer.
//
// Optional feature (macro LS595_CASCADE_EN): adds the ser_out cascade port.
// ser_out is a registered copy of the bit that leaves sr[0] on each shift,
// which is the QH' equivalent of the 74LS595.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   n_clr      asynchronous active-low reset
//   sclr       synchronous clear of the shift register, bit counter and
//              overflow flag (the storage register is kept)
//   shift_en   qualifies one serial bit per channel on this edge
//   ser_in     serial data; bit c belongs to channel c
//   word_ready consumer accepts word_out this cycle
//   word_valid storage register holds an unconsumed word
//   word_out   storage register; channel c is at [c*WIDTH +: WIDTH]
//   bit_cnt    bits received into the current word
//   overflow   sticky flag: a completed word was dropped
//   ser_out    cascade output (only with LS595_CASCADE_EN)

module ls595_deser #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 3
) (
    input  logic                          clk,
    input  logic                          n_clr,
    input  logic                          sclr,
    input  logic                          shift_en,
    input  logic [CHANNELS-1:0]           ser_in,
    input  logic                          word_ready,
    output logic                          word_valid,
    output logic [CHANNELS*WIDTH-1:0]     word_out,
    output logic [$clog2(WIDTH)-1:0]      bit_cnt,
    output logic                          overflow
`ifdef LS595_CASCADE_EN
    ,
    output logic [CHANNELS-1:0]           ser_out
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    // The counter is compared against WIDTH-1, so WIDTH does not have to be a power of two.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                            state_r;
    state_t                            state_nxt_s;
    logic [CHANNELS-1:0][WIDTH-1:0]    sr_r;
    logic [CHANNELS-1:0][WIDTH-1:0]    cand_s;
    logic [CNT_W-1:0]                  cnt_r;
    logic [CHANNELS*WIDTH-1:0]         store_r;
    logic                              ovf_r;
    logic                              complete_s;
    logic                              load_s;
    logic                              drop_s;

    // Shifted value of every channel for this edge. It is also the word-complete candidate.
    always_comb begin
        cand_s = sr_r;
        for (int c = 0; c < CHANNELS; c++) begin
            cand_s[c] = {ser_in[c], sr_r[c][WIDTH-1:1]};
        end
    end

    // The word is complete when the last bit arrives. sclr discards that bit.
    always_comb begin
        complete_s = 1'b0;
        if (shift_en && !sclr && (cnt_r == CNT_LAST)) begin
            complete_s = 1'b1;
        end else begin
            complete_s = 1'b0;
        end
    end

    // Storage FSM next-state logic: load, drop, or consume decisions.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (complete_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (complete_s && word_ready) begin
                    // Consume the old word and load the new one on the same edge, so there is no bubble.
                    load_s      = 1'b1;
                    state_nxt_s = ST_FULL;
                end else if (complete_s) begin
                    drop_s      = 1'b1;
                    state_nxt_s = ST_FULL;
                end else if (word_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Storage FSM state register.
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift register, bit counter and sticky overflow. sclr overrides shift_en.
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            sr_r  <= {(CHANNELS*WIDTH){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
        end else if (sclr) begin
            sr_r  <= {(CHANNELS*WIDTH){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            if (shift_en) begin
                sr_r  <= cand_s;
                cnt_r <= complete_s ? {CNT_W{1'b0}} : (cnt_r + CNT_ONE);
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Storage register. Only a load changes it; sclr leaves a pending word intact.
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            store_r <= {(CHANNELS*WIDTH){1'b0}};
        end else if (load_s) begin
            store_r <= cand_s;
        end
    end

`ifdef LS595_CASCADE_EN
    logic [CHANNELS-1:0] ser_r;

    // Cascade register that captures the bit leaving sr[0] on each shift.
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            ser_r <= {CHANNELS{1'b0}};
        end else if (sclr) begin
            ser_r <= {CHANNELS{1'b0}};
        end else if (shift_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ser_r[c] <= sr_r[c][0];
            end
        end
    end

    assign ser_out = ser_r;
`endif

    assign word_valid = (state_r == ST_FULL);
    assign word_out   = store_r;
    assign bit_cnt    = cnt_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_ls595_deser.sv
// tb_ls595_deser -- directed self-checking bench for ls595_deser (WIDTH=8, CHANNELS=3).
// A bit-level reference model pushes each expected stored word to a scoreboard
// queue when the completing bit is driven. The word is popped and compared when
// the DUT loads its storage register.

module tb_ls595_deser;

    logic        clk;
    logic        n_clr;
    logic        sclr;
    logic        shift_en;
    logic [2:0]  ser_in;
    logic        word_ready;
    logic        word_valid;
    logic [23:0] word_out;
    logic [2:0]  bit_cnt;
    logic        overflow;
`ifdef LS595_CASCADE_EN
    logic [2:0]  ser_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0]  m_sr [3];
    logic [2:0]  m_cnt;
    logic        m_full;
    logic        m_ovf;
    logic [2:0]  m_so;
    logic [23:0] sb [$];

    ls595_deser #(.WIDTH(8), .CHANNELS(3)) dut (
        .clk        (clk),
        .n_clr      (n_clr),
        .sclr       (sclr),
        .shift_en   (shift_en),
        .ser_in     (ser_in),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word_out   (word_out),
        .bit_cnt    (bit_cnt),
        .overflow   (overflow)
`ifdef LS595_CASCADE_EN
        ,
        .ser_out    (ser_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) m_sr[c] = 8'h00;
        m_cnt  = 3'd0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
        m_so   = 3'b000;
        sb.delete();
    endtask

    // One clock: drive inputs, advance the model, then check outputs #1 after the edge.
    task automatic cyc(input logic se, input logic [2:0] si, input logic rdy, input logic sc);
        logic        done;
        logic        loaded;
        logic [23:0] cand;
        logic [23:0] exp_w;
        shift_en   = se;
        ser_in     = si;
        word_ready = rdy;
        sclr       = sc;
        done   = 1'b0;
        loaded = 1'b0;
        cand   = 24'h0;
        if (sc) begin
            for (int c = 0; c < 3; c++) m_sr[c] = 8'h00;
            m_cnt = 3'd0;
            m_ovf = 1'b0;
            m_so  = 3'b000;
        end else if (se) begin
            for (int c = 0; c < 3; c++) begin
                cand[c*8 +: 8] = {si[c], m_sr[c][7:1]};
                m_so[c]        = m_sr[c][0];
                m_sr[c]        = cand[c*8 +: 8];
            end
            if (m_cnt == 3'd7) begin
                done  = 1'b1;
                m_cnt = 3'd0;
                if (!m_full || rdy) begin
                    sb.push_back(cand);
                    m_full = 1'b1;
                    loaded = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else begin
                m_cnt = m_cnt + 3'd1;
            end
        end
        if (!done && m_full && rdy) m_full = 1'b0;
        @(posedge clk);
        #1;
        chk("word_valid", {31'd0, word_valid}, {31'd0, m_full});
        chk("bit_cnt", {29'd0, bit_cnt}, {29'd0, m_cnt});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef LS595_CASCADE_EN
        chk("ser_out", {29'd0, ser_out}, {29'd0, m_so});
`endif
        if (loaded) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_w = sb.pop_front();
                chk("word_out", {8'd0, word_out}, {8'd0, exp_w});
            end
        end
    endtask

    // Eight shifts of one byte per channel. word_ready is raised only on the completing edge.
    task automatic word(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, {c[i], b[i], a[i]}, (i == 7) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
        chk({tag, "_word"}, {8'd0, word_out}, 32'd0);
        chk({tag, "_cnt"}, {29'd0, bit_cnt}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
`ifdef LS595_CASCADE_EN
        chk({tag, "_ser_out"}, {29'd0, ser_out}, 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] pat;
        n_clr      = 1'b0;
        sclr       = 1'b0;
        shift_en   = 1'b0;
        ser_in     = 3'b000;
        word_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        n_clr = 1'b1;

        // first word, latency 1, consumer not ready
        word(8'hA5, 8'h3C, 8'hFF, 1'b0);
        chk("t1_word", {8'd0, word_out}, 32'h00FF3CA5);
        chk("t1_valid", {31'd0, word_valid}, 32'd1);

        // second word dropped -> overflow, old word kept
        word(8'h11, 8'h22, 8'h33, 1'b0);
        chk("t2_ovf", {31'd0, overflow}, 32'd1);
        chk("t2_word", {8'd0, word_out}, 32'h00FF3CA5);
        cyc(1'b0, 3'b000, 1'b1, 1'b0);
        chk("t2_consumed", {31'd0, word_valid}, 32'd0);
        cyc(1'b0, 3'b000, 1'b0, 1'b1);

        // back-to-back: consume and reload on the same edge
        word(8'h01, 8'h01, 8'h01, 1'b0);
        chk("t3_word1", {8'd0, word_out}, 32'h00010101);
        word(8'h02, 8'h02, 8'h02, 1'b1);
        chk("t3_word2", {8'd0, word_out}, 32'h00020202);
        chk("t3_ovf", {31'd0, overflow}, 32'd0);

        // sclr mid-word with shift_en: counter/overflow cleared, pending word kept
        word(8'h77, 8'h77, 8'h77, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'b101, 1'b0, 1'b0);
        cyc(1'b1, 3'b111, 1'b0, 1'b1);
        chk("t4_cnt", {29'd0, bit_cnt}, 32'd0);
        chk("t4_valid", {31'd0, word_valid}, 32'd1);
        chk("t4_word", {8'd0, word_out}, 32'h00020202);
        chk("t4_ovf", {31'd0, overflow}, 32'd0);
        word(8'h5A, 8'h5A, 8'h5A, 1'b1);
        chk("t4_new", {8'd0, word_out}, 32'h005A5A5A);

        // asynchronous reset between edges, mid-word
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'b010, 1'b0, 1'b0);
        #3;
        n_clr = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        shift_en = 1'b0;
        @(negedge clk);
        n_clr = 1'b1;
        word(8'hC3, 8'hC3, 8'hC3, 1'b0);
        chk("t5_word", {8'd0, word_out}, 32'h00C3C3C3);

`ifdef LS595_CASCADE_EN
        // cascade: ch0 bits of 0xA5 reappear on ser_out[0] on shift edges 9..16
        pat = 8'hA5;
        word(pat, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'b000, (i == 7) ? 1'b1 : 1'b0, 1'b0);
            chk("cascade_bit", {31'd0, ser_out[0]}, {31'd0, pat[i]});
        end
`else
        pat = 8'h00;
        cyc(1'b0, 3'b000, 1'b0, 1'b0);
        chk("idle_hold", {8'd0, word_out}, 32'h00C3C3C3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
